// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state encodings, defaults and sizing helper for the serial chunk adder
package adder_pkg;

   // Controller states of the serial adder.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_CHUNK = 8;

   // Width of the chunk index counter; never narrower than one bit.
   function automatic int idx_width(input int num_chunks);
      return (num_chunks <= 1) ? 1 : $clog2(num_chunks);
   endfunction

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - CHUNK-bit combinational ripple adder built from full-adder cells
module chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             carry_msb
);

   logic carry;

   // Ripple the carry through one full-adder cell per bit; carry_msb is the carry entering the top bit.
   always_comb begin
      sum       = '0;
      carry     = cin;
      carry_msb = 1'b0;
      for (int i = 0; i < CHUNK; i++) begin
         if (i == CHUNK - 1) begin
            carry_msb = carry;
         end
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - multi-cycle add/subtract, CHUNK bits per clock with valid/ready handshakes
module serial_chunk_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CHUNK = DEFAULT_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NUM_CHUNKS = WIDTH / CHUNK;
   localparam int IDX_W      = idx_width(NUM_CHUNKS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   state_t             state;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [IDX_W-1:0]   idx;
   logic               carry;

   logic [CHUNK-1:0]   chunk_sum;
   logic               chunk_cout;
   logic               chunk_carry_msb;

   // Operand registers shift right each RUN cycle, so the current chunk always sits in the low bits.
   chunk_adder #(
      .CHUNK (CHUNK)
   ) u_chunk_adder (
      .a         (a_reg[CHUNK-1:0]),
      .b         (b_reg[CHUNK-1:0]),
      .cin       (carry),
      .sum       (chunk_sum),
      .cout      (chunk_cout),
      .carry_msb (chunk_carry_msb)
   );

   // Controller: capture operands in IDLE, add one chunk per cycle in RUN, hold the result in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         overflow  <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         idx       <= '0;
         carry     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_reg    <= a;
                  b_reg    <= sub ? ~b : b;
                  carry    <= sub ? 1'b1 : cin;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < NUM_CHUNKS; i++) begin
                  if (idx == IDX_W'(i)) begin
                     sum[i*CHUNK +: CHUNK] <= chunk_sum;
                  end
               end
               a_reg <= a_reg >> CHUNK;
               b_reg <= b_reg >> CHUNK;
               carry <= chunk_cout;
               if (idx == LAST_IDX) begin
                  cout      <= chunk_cout;
                  overflow  <= chunk_carry_msb ^ chunk_cout;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb/tb_serial_chunk_adder.sv - scoreboard bench for serial_chunk_adder with 8-, 32- and 1-bit chunk builds
module tb_serial_chunk_adder;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
   logic        overflow;

   logic        sw_in_valid;
   logic [31:0] sw_a;
   logic [31:0] sw_b;
   logic        sw_zero;
   logic        sw_out_ready;
   logic        w_in_ready, w_out_valid, w_cout, w_ovf;
   logic [31:0] w_sum;
   logic        n_in_ready, n_out_valid, n_cout, n_ovf;
   logic [31:0] n_sum;

   int   n_pass = 0;
   int   n_total = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   serial_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .overflow(overflow)
   );

   serial_chunk_adder #(.WIDTH(32), .CHUNK(32)) dut_wide (
      .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(w_in_ready),
      .a(sw_a), .b(sw_b), .cin(sw_zero), .sub(sw_zero),
      .out_valid(w_out_valid), .out_ready(sw_out_ready),
      .sum(w_sum), .cout(w_cout), .overflow(w_ovf)
   );

   serial_chunk_adder #(.WIDTH(32), .CHUNK(1)) dut_bit (
      .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(n_in_ready),
      .a(sw_a), .b(sw_b), .cin(sw_zero), .sub(sw_zero),
      .out_valid(n_out_valid), .out_ready(sw_out_ready),
      .sum(n_sum), .cout(n_cout), .overflow(n_ovf)
   );

   function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb,
                                  input logic tcin, input logic tsub);
      logic [31:0] bb;
      logic [32:0] s;
      exp_t        e;
      bb    = tsub ? ~tb : tb;
      s     = {1'b0, ta} + {1'b0, bb} + {32'd0, (tsub ? 1'b1 : tcin)};
      e.sum = s[31:0];
      e.cout = s[32];
      e.ovf = (ta[31] == bb[31]) && (s[31] != ta[31]);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input logic [31:0] ta, input logic [31:0] tb,
                          input logic tcin, input logic tsub, input bit bp);
      exp_t e;
      int   lat;
      int   w;
      sb.push_back(model(ta, tb, tcin, tsub));
      a = ta; b = tb; cin = tcin; sub = tsub;
      in_valid  = 1'b1;
      out_ready = !bp;
      w = 0;
      while (!in_ready && w < 50) begin step(); w++; end
      chk("accept_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("run_in_ready_low", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 100) begin step(); lat++; end
      chk("latency", lat, 4);
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
         return;
      end
      e = sb.pop_front();
      chk("sum", sum, e.sum);
      chk("cout", cout, e.cout);
      chk("overflow", overflow, e.ovf);
      if (bp) begin
         a = 32'hAAAA_5555; b = 32'h1234_5678; cin = 1'b0; sub = 1'b0;
         in_valid = 1'b1;
         for (int i = 0; i < 6; i++) begin
            step();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_sum", sum, e.sum);
            chk("bp_flags", {cout, overflow}, {e.cout, e.ovf});
            chk("bp_in_ready", in_ready, 0);
         end
         out_ready = 1'b1;
         step();
         in_valid = 1'b0;
         chk("release_out_valid", out_valid, 0);
         chk("release_in_ready", in_ready, 1);
      end else begin
         step();
         chk("consumed_out_valid", out_valid, 0);
         chk("idle_in_ready", in_ready, 1);
      end
   endtask

   initial begin
      int lat_w;
      int lat_n;
      logic [31:0] cap_w, cap_n;
      logic [1:0]  flg_w, flg_n;
      exp_t        es;

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      sw_in_valid = 1'b0; sw_a = 32'hDEAD_BEEF; sw_b = 32'h1111_1111; sw_zero = 1'b0; sw_out_ready = 1'b1;
      step();
      step();
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_sum", sum, 0);
      chk("reset_flags", {cout, overflow}, 2'b00);
      rst = 1'b0;

      run_txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      run_txn(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      run_txn(32'h1234_5678, 32'h0000_00FF, 1'b1, 1'b0, 1'b0);
      run_txn(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0);
      run_txn(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0);
      run_txn(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0, 1'b1);
      run_txn(32'hAAAA_5555, 32'h1234_5678, 1'b0, 1'b0, 1'b0);

      // abort an operation on its second RUN cycle
      a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_sum", sum, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_flags", {cout, overflow}, 2'b00);
      run_txn(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 1'b0);

      // chunk-width sweep: full-width and bit-serial builds
      es = model(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0);
      chk("sweep_ready_wide", w_in_ready, 1);
      chk("sweep_ready_bit", n_in_ready, 1);
      sw_in_valid = 1'b1;
      step();
      sw_in_valid = 1'b0;
      lat_w = -1; lat_n = -1;
      cap_w = '0; cap_n = '0; flg_w = '0; flg_n = '0;
      for (int c = 1; c <= 40; c++) begin
         step();
         if (w_out_valid && lat_w < 0) begin lat_w = c; cap_w = w_sum; flg_w = {w_cout, w_ovf}; end
         if (n_out_valid && lat_n < 0) begin lat_n = c; cap_n = n_sum; flg_n = {n_cout, n_ovf}; end
      end
      chk("sweep_latency_wide", lat_w, 1);
      chk("sweep_latency_bit", lat_n, 32);
      chk("sweep_sum_wide", cap_w, es.sum);
      chk("sweep_sum_bit", cap_n, es.sum);
      chk("sweep_flags_wide", flg_w, {es.cout, es.ovf});
      chk("sweep_flags_bit", flg_n, {es.cout, es.ovf});
      chk("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
